// File: rtl/motor_interlock.sv
// Motor drive interlock: turns raw forward/reverse requests into shoot-through-safe
// drive lines with minimum on-time, dead-time, fault latching and a reversal counter.
module motor_interlock #(
  parameter int MIN_ON   = 3,
  parameter int DEAD_CYC = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             zheng_req,
  input  logic             fan_req,
  input  logic             emergency,
  output logic             zheng_drv,
  output logic             fan_drv,
  output logic             brake,
  output logic             fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] rev_count
);

  localparam int ON_W   = (MIN_ON > 1) ? $clog2(MIN_ON + 1) : 1;
  localparam int DEAD_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC + 1) : 1;
  localparam logic [ON_W-1:0]   ON_LOAD   = ON_W'(MIN_ON - 1);
  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYC - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FWD   = 3'd1,
    REV   = 3'd2,
    DEAD  = 3'd3,
    FAULT = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_FWD  = 2'd1,
    DIR_REV  = 2'd2
  } dir_t;

  state_t            cur, nxt;
  dir_t              last_dir, last_nxt;
  logic [ON_W-1:0]   on_cnt, on_nxt;
  logic [DEAD_W-1:0] dead_cnt, dead_nxt;
  logic [CNT_W-1:0]  cnt_nxt;

  always_comb begin
    nxt      = cur;
    last_nxt = last_dir;
    on_nxt   = on_cnt;
    dead_nxt = dead_cnt;
    cnt_nxt  = rev_count;
    // Emergency or contradictory requests win over any timer.
    if (emergency || (zheng_req && fan_req)) begin
      nxt = FAULT;
    end else begin
      case (cur)
        IDLE: begin
          if (zheng_req) begin
            nxt      = FWD;
            on_nxt   = ON_LOAD;
            last_nxt = DIR_FWD;
            if (last_dir == DIR_REV) cnt_nxt = rev_count + CNT_W'(1);
          end else if (fan_req) begin
            nxt      = REV;
            on_nxt   = ON_LOAD;
            last_nxt = DIR_REV;
            if (last_dir == DIR_FWD) cnt_nxt = rev_count + CNT_W'(1);
          end
        end
        FWD: begin
          if (on_cnt != '0) begin
            on_nxt = on_cnt - ON_W'(1);
          end else if (!zheng_req || fan_req) begin
            nxt      = DEAD;
            dead_nxt = DEAD_LOAD;
          end
        end
        REV: begin
          if (on_cnt != '0) begin
            on_nxt = on_cnt - ON_W'(1);
          end else if (!fan_req || zheng_req) begin
            nxt      = DEAD;
            dead_nxt = DEAD_LOAD;
          end
        end
        DEAD: begin
          if (dead_cnt == '0) nxt = IDLE;
          else                dead_nxt = dead_cnt - DEAD_W'(1);
        end
        FAULT: begin
          if (!zheng_req && !fan_req) begin
            nxt      = DEAD;
            dead_nxt = DEAD_LOAD;
          end
        end
        default: nxt = FAULT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur       <= IDLE;
      last_dir  <= DIR_NONE;
      on_cnt    <= '0;
      dead_cnt  <= '0;
      rev_count <= '0;
      zheng_drv <= 1'b0;
      fan_drv   <= 1'b0;
      brake     <= 1'b0;
      fault     <= 1'b0;
    end else begin
      cur       <= nxt;
      last_dir  <= last_nxt;
      on_cnt    <= on_nxt;
      dead_cnt  <= dead_nxt;
      rev_count <= cnt_nxt;
      // Outputs decoded from the next state so they change together with it.
      zheng_drv <= (nxt == FWD);
      fan_drv   <= (nxt == REV);
      brake     <= (nxt == DEAD) || (nxt == FAULT);
      fault     <= (nxt == FAULT);
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_motor_interlock.sv
// Bench for motor_interlock: directed and random request patterns run through a
// timing-level reference model; a monitor compares every cycle against a queue.
module tb_motor_interlock;

  localparam int MIN_ON   = 3;
  localparam int DEAD_CYC = 2;
  localparam int CNT_W    = 8;
  localparam int OW       = 7 + CNT_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             zheng_req, fan_req, emergency;
  logic             zheng_drv, fan_drv, brake, fault;
  logic [2:0]       state;
  logic [CNT_W-1:0] rev_count;

  motor_interlock #(.MIN_ON(MIN_ON), .DEAD_CYC(DEAD_CYC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .zheng_req(zheng_req), .fan_req(fan_req), .emergency(emergency),
    .zheng_drv(zheng_drv), .fan_drv(fan_drv), .brake(brake), .fault(fault),
    .state(state), .rev_count(rev_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [OW-1:0] exp_q[$];

  // ---------------- reference model ----------------
  // Phases: idle, running (direction in m_dir), dead-time, fault.
  localparam int PH_IDLE = 0, PH_RUN = 1, PH_DEAD = 2, PH_FAULT = 3;
  int m_phase, m_dir, m_last, m_run, m_dead_left, m_rev;

  task automatic model_reset();
    m_phase = PH_IDLE; m_dir = 0; m_last = 0; m_run = 0; m_dead_left = 0; m_rev = 0;
  endtask

  task automatic model_start(input int d);
    m_phase = PH_RUN;
    m_dir   = d;
    m_run   = 1;
    if (m_last != 0 && m_last != d) m_rev = (m_rev + 1) % (1 << CNT_W);
    m_last = d;
  endtask

  task automatic model_step(input bit z, input bit f, input bit e);
    if (e || (z && f)) begin
      m_phase = PH_FAULT;
    end else begin
      case (m_phase)
        PH_IDLE: if (z) model_start(1); else if (f) model_start(2);
        PH_RUN: begin
          bit want_off;
          want_off = (m_dir == 1) ? (!z || f) : (!f || z);
          if (m_run >= MIN_ON && want_off) begin
            m_phase = PH_DEAD; m_dead_left = DEAD_CYC;
          end else m_run++;
        end
        PH_DEAD: if (m_dead_left == 1) m_phase = PH_IDLE; else m_dead_left--;
        default: if (!z && !f) begin m_phase = PH_DEAD; m_dead_left = DEAD_CYC; end
      endcase
    end
  endtask

  function automatic logic [OW-1:0] model_out();
    logic zd, fd, br, fl;
    logic [2:0] st;
    zd = (m_phase == PH_RUN) && (m_dir == 1);
    fd = (m_phase == PH_RUN) && (m_dir == 2);
    br = (m_phase == PH_DEAD) || (m_phase == PH_FAULT);
    fl = (m_phase == PH_FAULT);
    case (m_phase)
      PH_IDLE: st = 3'd0;
      PH_RUN:  st = (m_dir == 1) ? 3'd1 : 3'd2;
      PH_DEAD: st = 3'd3;
      default: st = 3'd4;
    endcase
    return {zd, fd, br, fl, st, CNT_W'(m_rev)};
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge: apply inputs, predict the next edge, wait a cycle.
  task automatic step(input bit z, input bit f, input bit e);
    zheng_req = z; fan_req = f; emergency = e;
    model_step(z, f, e);
    exp_q.push_back(model_out());
    @(negedge clk);
  endtask

  task automatic hold(input bit z, input bit f, input bit e, input int n);
    for (int i = 0; i < n; i++) step(z, f, e);
  endtask

  task automatic check_reset_outputs(input string name);
    logic [OW-1:0] got;
    got = {zheng_drv, fan_drv, brake, fault, state, rev_count};
    n_checks++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL %s got z%b f%b brk%b flt%b st%0d rev%0d required all zero",
               name, zheng_drv, fan_drv, brake, fault, state, rev_count);
    end
  endtask

  // Reset pulse placed between clock edges; returns at a negedge with rst released.
  task automatic async_reset(input string name);
    @(posedge clk);
    #3 rst = 1'b0;
    #1 check_reset_outputs(name);
    model_reset();
    zheng_req = 0; fan_req = 0; emergency = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) begin
    logic [OW-1:0] exp_v, got_v;
    #1;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      got_v = {zheng_drv, fan_drv, brake, fault, state, rev_count};
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL out t=%0t got z%b f%b brk%b flt%b st%0d rev%0d required z%b f%b brk%b flt%b st%0d rev%0d",
                 $time, got_v[OW-1], got_v[OW-2], got_v[OW-3], got_v[OW-4], got_v[OW-5 -: 3],
                 got_v[CNT_W-1:0], exp_v[OW-1], exp_v[OW-2], exp_v[OW-3], exp_v[OW-4],
                 exp_v[OW-5 -: 3], exp_v[CNT_W-1:0]);
      end
    end
  end

  // Shoot-through and drive-during-fault invariant, every cycle.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      n_checks++;
      assert (!(zheng_drv && fan_drv) && !(fault && (zheng_drv || fan_drv)))
      else begin
        n_fail++;
        $display("FAIL invariant t=%0t got z%b f%b flt%b required no overlap", $time,
                 zheng_drv, fan_drv, fault);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; zheng_req = 0; fan_req = 0; emergency = 0;
    model_reset();
    #1 check_reset_outputs("reset_state");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    hold(1, 0, 0, 10); hold(0, 0, 0, 4);             // held forward request
    hold(1, 0, 0, 1);  hold(0, 0, 0, 7);             // one-cycle pulse -> MIN_ON
    hold(1, 0, 0, 5);  hold(0, 1, 0, 6); hold(0, 0, 0, 4); // forward then reverse
    for (int i = 0; i < 256; i++) begin              // many reversals, counter wraps
      hold(1, 0, 0, 7); hold(0, 1, 0, 7);
    end
    hold(0, 0, 0, 4);
    hold(1, 0, 0, 2); hold(0, 0, 1, 1); hold(0, 0, 0, 5); // emergency inside MIN_ON
    hold(1, 1, 0, 3); hold(1, 0, 0, 2); hold(0, 0, 0, 5); // both requests
    hold(1, 0, 0, 2);
    async_reset("async_reset");
    hold(0, 1, 0, 5); hold(0, 0, 0, 4);              // first start after reset

    for (int seg = 0; seg < 400; seg++) begin
      int r, len;
      bit z, f, e;
      r = $urandom_range(0, 99);
      len = $urandom_range(1, 8);
      e = (r < 5);
      z = (r >= 5 && r < 12) || (r >= 12 && r < 50);
      f = (r >= 5 && r < 12) || (r >= 50 && r < 85);
      if (e) len = 1;
      hold(z, f, e, len);
    end
    hold(0, 0, 0, 6);

    @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain got %0d pending required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
